// File: rtl/apb_protocol_checker22.sv
// Passive APB3 protocol checker: tracks transfers and flags violations in a sticky vector.
// Latency: bus sampled on each pclock22 rise, every output registered (1 cycle).
// Backpressure: none, monitor only; follows pready22 stalls and drives no bus signal.
//
// Ports: APB bus inputs (paddr22, prwd22, pwdata22, penable22, psel22, prdata22,
//        pslverr22, pready22), control inputs chk_en22 / err_clr22, outputs
//        err_vec22 / err_pulse22 (violations), xfer_cnt22 / slverr_cnt22 / max_wait22
//        (saturating statistics) and xfer_done22 (completion strobe).
// Optional X/Z checking (err_vec22[7]) is compiled in when APB_CHK_XZ_EN is defined.
module apb_protocol_checker22 #(
    parameter int PADDR_WIDTH22  = 32,
    parameter int PWDATA_WIDTH22 = 32,
    parameter int PRDATA_WIDTH22 = 32,
    parameter int NUM_SLAVES22   = 16,
    parameter int TIMEOUT_CYC22  = 256,
    parameter int CNT_WIDTH22    = 16
) (
    input  logic                      pclock22,
    input  logic                      preset22,
    input  logic [PADDR_WIDTH22-1:0]  paddr22,
    input  logic                      prwd22,
    input  logic [PWDATA_WIDTH22-1:0] pwdata22,
    input  logic                      penable22,
    input  logic [NUM_SLAVES22-1:0]   psel22,
    input  logic [PRDATA_WIDTH22-1:0] prdata22,
    input  logic                      pslverr22,
    input  logic                      pready22,
    input  logic                      chk_en22,
    input  logic                      err_clr22,
    output logic [7:0]                err_vec22,
    output logic                      err_pulse22,
    output logic [CNT_WIDTH22-1:0]    xfer_cnt22,
    output logic [CNT_WIDTH22-1:0]    slverr_cnt22,
    output logic [CNT_WIDTH22-1:0]    max_wait22,
    output logic                      xfer_done22
);

    localparam int WW = $clog2(TIMEOUT_CYC22 + 1);

    // IDLE: no transfer; SETUP: last sampled cycle was a setup phase;
    // ACCESS: last sampled cycle was an access phase stalled by pready22=0.
    typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2} state_t;

    state_t                    state_q, state_d;
    logic [WW-1:0]             wait_q, wait_d;
    logic [NUM_SLAVES22-1:0]   cap_sel_q;
    logic [PADDR_WIDTH22-1:0]  cap_addr_q;
    logic                      cap_wr_q;
    logic [PWDATA_WIDTH22-1:0] cap_wdat_q;
    logic                      arm_q, arm_d;
    logic                      capture, cmpl, chk_eff;
    logic [7:0]                set_raw, set_bits;
    logic                      any_sel, multi_sel, mismatch;
    logic [NUM_SLAVES22-1:0]   psel_m1;
    logic [CNT_WIDTH22-1:0]    wait_ext;
    logic                      prdata_unused;

    assign any_sel   = |psel22;
    assign psel_m1   = psel22 - NUM_SLAVES22'(1);
    // Clearing the lowest set bit leaves something only if two or more bits were set.
    assign multi_sel = |(psel22 & psel_m1);
    assign mismatch  = (paddr22 != cap_addr_q) || (prwd22 != cap_wr_q) ||
                       (psel22 != cap_sel_q) || (cap_wr_q && (pwdata22 != cap_wdat_q));
    assign wait_ext  = CNT_WIDTH22'(wait_q);
    assign prdata_unused = ^prdata22;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        capture = 1'b0;
        cmpl    = 1'b0;
        set_raw = 8'h00;
        set_raw[0] = multi_sel;
        set_raw[6] = xfer_done22 & penable22;
        case (state_q)
            IDLE: begin
                // The cycle right after a completion is owned by bit 6.
                set_raw[1] = penable22 & ~xfer_done22;
                if (any_sel && !penable22) begin
                    capture = 1'b1;
                    state_d = SETUP;
                    wait_d  = '0;
                end
            end
            SETUP, ACCESS: begin
                if (any_sel && penable22) begin
                    set_raw[3] = mismatch;
                    if (pready22) begin
                        cmpl    = 1'b1;
                        state_d = IDLE;
                        wait_d  = '0;
                    end else begin
                        state_d = ACCESS;
                        if (wait_q != WW'(TIMEOUT_CYC22)) wait_d = wait_q + WW'(1);
                        // Fires only on the step that reaches the limit, so once per transfer.
                        set_raw[4] = (wait_q == WW'(TIMEOUT_CYC22 - 1));
                    end
                end else if (!any_sel) begin
                    set_raw[5] = (state_q == ACCESS) & ~pready22;
                    state_d    = IDLE;
                    wait_d     = '0;
                end else begin
                    // Selected with penable low: abandon the transfer and treat as a new setup.
                    set_raw[2] = (state_q == ACCESS) & ~pready22;
                    capture    = 1'b1;
                    state_d    = SETUP;
                    wait_d     = '0;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
`ifdef APB_CHK_XZ_EN
        set_raw[7] = $isunknown(penable22) | $isunknown(psel22)
                   | (any_sel & ($isunknown(paddr22) | $isunknown(prwd22)
                                 | (prwd22 & $isunknown(pwdata22))))
                   | (cmpl & ($isunknown(pslverr22) | (~cap_wr_q & $isunknown(prdata22))));
`endif
    end

    // Once checking is switched off it stays off until a new setup phase is seen.
    assign chk_eff  = chk_en22 & (arm_q | capture);
    assign arm_d    = capture ? chk_en22 : (arm_q & chk_en22);
    assign set_bits = chk_eff ? set_raw : 8'h00;

    always_ff @(posedge pclock22 or negedge preset22) begin
        if (!preset22) begin
            state_q      <= IDLE;
            wait_q       <= '0;
            cap_sel_q    <= '0;
            cap_addr_q   <= '0;
            cap_wr_q     <= 1'b0;
            cap_wdat_q   <= '0;
            arm_q        <= 1'b1;
            err_vec22    <= 8'h00;
            err_pulse22  <= 1'b0;
            xfer_done22  <= 1'b0;
            xfer_cnt22   <= '0;
            slverr_cnt22 <= '0;
            max_wait22   <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            arm_q       <= arm_d;
            if (capture) begin
                cap_sel_q  <= psel22;
                cap_addr_q <= paddr22;
                cap_wr_q   <= prwd22;
                cap_wdat_q <= pwdata22;
            end
            // A bit being set wins over a clear on the same edge.
            err_vec22   <= (err_clr22 ? 8'h00 : err_vec22) | set_bits;
            err_pulse22 <= |(set_bits & ~err_vec22);
            xfer_done22 <= cmpl;
            if (cmpl) begin
                if (xfer_cnt22 != '1) xfer_cnt22 <= xfer_cnt22 + CNT_WIDTH22'(1);
                if (pslverr22 && (slverr_cnt22 != '1))
                    slverr_cnt22 <= slverr_cnt22 + CNT_WIDTH22'(1);
                if (wait_ext > max_wait22) max_wait22 <= wait_ext;
            end
        end
    end

endmodule

// File: tb/tb_apb_protocol_checker22.sv
// Bench for apb_protocol_checker22: directed scenarios plus randomized transfers.
// Latency: outputs compared every cycle, 1 ns after the rising edge, against a reference model.
// Backpressure: pready22 stalls, aborts and glitches are generated by the stimulus.
module tb_apb_protocol_checker22;

    localparam int NS = 4;
    localparam int T  = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          pclock22 = 1'b0;
    logic          preset22;
    logic [31:0]   paddr22, pwdata22, prdata22;
    logic          prwd22, penable22, pslverr22, pready22, chk_en22, err_clr22;
    logic [NS-1:0] psel22;
    logic [7:0]    err_vec22;
    logic          err_pulse22, xfer_done22;
    logic [CW-1:0] xfer_cnt22, slverr_cnt22, max_wait22;

    always #5 pclock22 = ~pclock22;

    apb_protocol_checker22 #(
        .PADDR_WIDTH22(32), .PWDATA_WIDTH22(32), .PRDATA_WIDTH22(32),
        .NUM_SLAVES22(NS), .TIMEOUT_CYC22(T), .CNT_WIDTH22(CW)
    ) dut (
        .pclock22(pclock22), .preset22(preset22), .paddr22(paddr22), .prwd22(prwd22),
        .pwdata22(pwdata22), .penable22(penable22), .psel22(psel22), .prdata22(prdata22),
        .pslverr22(pslverr22), .pready22(pready22), .chk_en22(chk_en22),
        .err_clr22(err_clr22), .err_vec22(err_vec22), .err_pulse22(err_pulse22),
        .xfer_cnt22(xfer_cnt22), .slverr_cnt22(slverr_cnt22), .max_wait22(max_wait22),
        .xfer_done22(xfer_done22)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;
    int pulse_seen = 0;
    bit checking = 0;

    // Reference model. m_age: -1 when no transfer is open, otherwise the number of
    // stalled access cycles seen since the setup phase (0 right after setup).
    int          m_age;
    bit          m_prev_done, m_armed;
    logic [31:0] m_addr, m_wd;
    logic        m_wr;
    logic [NS-1:0] m_sel;
    int          m_xfer, m_slv, m_max;
    logic [7:0]  m_vec;
    bit          m_pulse, m_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_age = -1; m_prev_done = 0; m_armed = 1;
        m_addr = '0; m_wd = '0; m_wr = 0; m_sel = '0;
        m_xfer = 0; m_slv = 0; m_max = 0;
        m_vec = 8'h00; m_pulse = 0; m_done = 0;
    endtask

    // Predicts the outputs that follow the next rising edge from the current inputs.
    task automatic model_step();
        bit any, setup_now, cmpl, ok;
        logic [7:0] s;
        int wt;
        s = 8'h00; setup_now = 0; cmpl = 0;
        any = (psel22 != '0);
        if ($countones(psel22) > 1) s[0] = 1'b1;
        if (m_prev_done && penable22) s[6] = 1'b1;
        if (m_age < 0) begin
            if (penable22 && !m_prev_done) s[1] = 1'b1;
            if (any && !penable22) setup_now = 1;
        end else if (any && penable22) begin
            if (paddr22 != m_addr || prwd22 != m_wr || psel22 != m_sel ||
                (m_wr && pwdata22 != m_wd)) s[3] = 1'b1;
            if (pready22) begin
                cmpl = 1;
                wt = (m_age < T) ? m_age : T;
                if (wt > m_max) m_max = wt;
                if (m_xfer < CMAX) m_xfer++;
                if (pslverr22 && m_slv < CMAX) m_slv++;
                m_age = -1;
            end else begin
                if (m_age + 1 == T) s[4] = 1'b1;
                m_age++;
            end
        end else if (!any) begin
            if (m_age > 0 && !pready22) s[5] = 1'b1;
            m_age = -1;
        end else begin
            if (m_age > 0 && !pready22) s[2] = 1'b1;
            setup_now = 1;
        end
`ifdef APB_CHK_XZ_EN
        if ($isunknown(penable22) || $isunknown(psel22) ||
            (any && ($isunknown(paddr22) || $isunknown(prwd22) ||
                     (prwd22 === 1'b1 && $isunknown(pwdata22)))) ||
            (cmpl && ($isunknown(pslverr22) || (!m_wr && $isunknown(prdata22)))))
            s[7] = 1'b1;
`endif
        ok = chk_en22 && (m_armed || setup_now);
        if (!ok) s = 8'h00;
        if (setup_now) begin
            m_age = 0; m_addr = paddr22; m_wr = prwd22; m_wd = pwdata22; m_sel = psel22;
        end
        m_armed = setup_now ? chk_en22 : (m_armed && chk_en22);
        m_pulse = ((s & ~m_vec) != 8'h00);
        m_vec = (err_clr22 ? 8'h00 : m_vec) | s;
        m_done = cmpl;
        m_prev_done = cmpl;
    endtask

    always @(posedge pclock22) begin
        #1;
        if (checking) begin
            chk("err_vec", err_vec22, m_vec);
            chk("err_pulse", err_pulse22, m_pulse);
            chk("xfer_done", xfer_done22, m_done);
            chk("xfer_cnt", xfer_cnt22, m_xfer);
            chk("slverr_cnt", slverr_cnt22, m_slv);
            chk("max_wait", max_wait22, m_max);
            if (xfer_done22 === 1'b1) done_seen++;
            if (err_pulse22 === 1'b1) pulse_seen++;
        end
    end

    // One bus cycle: drive at the falling edge, then advance the model to the next edge.
    task automatic cyc(input logic [NS-1:0] s, input logic e, input logic r,
                       input logic [31:0] a = 32'h10, input logic w = 1'b1,
                       input logic [31:0] d = 32'hA5A5, input logic se = 1'b0,
                       input logic ce = 1'b1, input logic cl = 1'b0);
        @(negedge pclock22);
        psel22 = s; penable22 = e; pready22 = r; paddr22 = a; prwd22 = w;
        pwdata22 = d; pslverr22 = se; chk_en22 = ce; err_clr22 = cl;
        prdata22 = $urandom();
        model_step();
    endtask

    function automatic logic rce();
        return ($urandom_range(0, 19) != 0);
    endfunction

    function automatic logic rcl();
        return ($urandom_range(0, 11) == 0);
    endfunction

    task automatic rcyc(input logic [NS-1:0] s, input logic e, input logic r,
                        input logic [31:0] a, input logic w, input logic [31:0] d,
                        input logic se);
        cyc(s, e, r, a, w, d, se, rce(), rcl());
    endtask

    task automatic settle();
        @(posedge pclock22);
        #2;
    endtask

    task automatic idle_inputs();
        psel22 = '0; penable22 = 0; pready22 = 0; paddr22 = '0; prwd22 = 0;
        pwdata22 = '0; pslverr22 = 0; chk_en22 = 1; err_clr22 = 0; prdata22 = '0;
    endtask

    task automatic release_rst();
        @(negedge pclock22);
        idle_inputs();
        preset22 = 1'b1;
        model_step();
        checking = 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_err_vec"}, err_vec22, 0);
        chk({tag, "_err_pulse"}, err_pulse22, 0);
        chk({tag, "_xfer_done"}, xfer_done22, 0);
        chk({tag, "_xfer_cnt"}, xfer_cnt22, 0);
        chk({tag, "_slverr_cnt"}, slverr_cnt22, 0);
        chk({tag, "_max_wait"}, max_wait22, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NS-1:0] s;
        logic [31:0] a, d, aa, dd;
        logic w;
        int nw, r;
        bit aborted;

        idle_inputs();
        preset22 = 1'b0;
        model_reset();
        repeat (3) @(negedge pclock22);
        check_all_zero("reset");
        release_rst();

        // Write to 0x10 with two wait cycles.
        done_seen = 0;
        cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 1); cyc(0, 0, 0);
        settle();
        chk("d1_xfer_cnt", xfer_cnt22, 1);
        chk("d1_max_wait", max_wait22, 2);
        chk("d1_err_vec", err_vec22, 0);
        chk("d1_done_pulses", done_seen, 1);

        // Multi-hot select: suppressed with chk_en22=0, flagged once re-armed by a setup.
        cyc(3, 0, 0, 32'h10, 1, 32'hA5A5, 0, 0);
        settle();
        chk("d2_masked", err_vec22, 0);
        cyc(0, 0, 0);
        cyc(3, 0, 0);
        settle();
        chk("d2_err_vec", err_vec22, 8'h01);
        chk("d2_pulse_hi", err_pulse22, 1);
        cyc(0, 0, 0);
        settle();
        chk("d2_pulse_lo", err_pulse22, 0);
        chk("d2_sticky", err_vec22, 8'h01);
        cyc(0, 0, 0, 32'h10, 1, 32'hA5A5, 0, 1, 1);
        settle();
        chk("d2_cleared", err_vec22, 0);

        // Address changes during an access wait.
        cyc(1, 0, 0, 32'h10); cyc(1, 1, 0, 32'h10); cyc(1, 1, 0, 32'h14);
        settle();
        chk("d3_err_vec", err_vec22, 8'h08);
        cyc(1, 1, 1, 32'h14); cyc(0, 0, 0);
        settle();
        chk("d3_xfer_cnt", xfer_cnt22, 2);
        cyc(0, 0, 0, 32'h10, 1, 32'hA5A5, 0, 1, 1);

        // Timeout: ten stalled cycles with a limit of four.
        pulse_seen = 0;
        cyc(1, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(1, 1, 0);
            settle();
            if (i == 3) chk("d4_before", err_vec22, 0);
            if (i == 4) chk("d4_timeout", err_vec22, 8'h10);
        end
        cyc(1, 1, 1); cyc(0, 0, 0);
        settle();
        chk("d4_pulses", pulse_seen, 1);
        chk("d4_max_wait", max_wait22, 4);
        chk("d4_xfer_cnt", xfer_cnt22, 3);
        cyc(0, 0, 0, 32'h10, 1, 32'hA5A5, 0, 1, 1);

        // Back-to-back read with slave error, then write.
        cyc(2, 0, 0, 32'h20, 0); cyc(2, 1, 1, 32'h20, 0, 32'h0, 1);
        cyc(4, 0, 0, 32'h30, 1, 32'h1234); cyc(4, 1, 1, 32'h30, 1, 32'h1234);
        cyc(0, 0, 0);
        settle();
        chk("d5_xfer_cnt", xfer_cnt22, 5);
        chk("d5_slverr_cnt", slverr_cnt22, 1);
        chk("d5_err_vec", err_vec22, 0);

`ifdef APB_CHK_XZ_EN
        cyc(1, 0, 0, 32'hx);
        cyc(0, 0, 0);
        settle();
        chk("xz_bit7", err_vec22[7], 1);
        cyc(0, 0, 0, 32'h10, 1, 32'hA5A5, 0, 1, 1);
`endif

        // Randomized transfers with occasional protocol violations.
        for (int t = 0; t < 400; t++) begin
            s = NS'(1) << $urandom_range(0, NS - 1);
            if ($urandom_range(0, 15) == 0) s = s | (NS'(1) << $urandom_range(0, NS - 1));
            a = $urandom() & 32'h3FC;
            d = $urandom();
            w = $urandom_range(0, 1) == 1;
            for (int k = $urandom_range(0, 2); k > 0; k--)
                rcyc(0, $urandom_range(0, 29) == 0, 0, 0, 0, 0, 0);
            rcyc(s, $urandom_range(0, 29) == 0, 0, a, w, d, 0);
            nw = $urandom_range(0, 6);
            aborted = 0;
            for (int k = 0; k < nw && !aborted; k++) begin
                r = $urandom_range(0, 39);
                aa = (r == 2) ? (a ^ 32'h4) : a;
                dd = (r == 3) ? (d ^ 32'h1) : d;
                if (r == 0) begin
                    rcyc(0, 0, $urandom_range(0, 1) == 1, a, w, d, 0);
                    aborted = 1;
                end else if (r == 1) begin
                    rcyc(s, 0, $urandom_range(0, 1) == 1, a, w, d, 0);
                    aborted = 1;
                end else begin
                    rcyc(s, 1, 0, aa, w, dd, 0);
                end
            end
            if (!aborted) begin
                rcyc(s, 1, 1, a, w, d, $urandom_range(0, 3) == 0);
                if ($urandom_range(0, 7) == 0) rcyc(0, 1, 0, 0, 0, 0, 0);
            end
        end
        cyc(0, 0, 0);
        cyc(0, 0, 0);

        // Reset in the middle of an access phase.
        cyc(1, 0, 0); cyc(1, 1, 0);
        settle();
        checking = 0;
        preset22 = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        idle_inputs();
        repeat (2) @(negedge pclock22);
        release_rst();
        cyc(1, 0, 0); cyc(1, 1, 1); cyc(0, 0, 0);
        settle();
        chk("d6_xfer_cnt", xfer_cnt22, 1);
        chk("d6_err_vec", err_vec22, 0);

        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
